// File: rtl/binconv_accum_kernel.sv
// XNOR-popcount binary convolution kernel: NK kernels evaluated in parallel,
// popcounts accumulated over N_SLICES beats, thresholded into binary activations.
module binconv_accum_kernel #(
  parameter  int D_SLICE   = 64,
  parameter  int FH        = 3,
  parameter  int FW        = 3,
  parameter  int N_SLICES  = 8,
  parameter  int NK        = 4,
  localparam int SLICE_W   = D_SLICE * FH * FW,
  localparam int ACC_WIDTH = $clog2(SLICE_W * N_SLICES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE_W-1:0]      fmap_in,
  input  logic [NK*SLICE_W-1:0]   weight,
  input  logic [NK*ACC_WIDTH-1:0] threshold,
  input  logic [NK-1:0]           polarity,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NK*ACC_WIDTH-1:0] acc_out,
  output logic [NK-1:0]           bin_out
);

  localparam int PC_W  = $clog2(SLICE_W + 1);
  localparam int CNT_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES - 1);

  logic                 en;
  logic                 accept;
  logic                 last_beat;
  logic                 load_result;
  logic [CNT_W-1:0]     cnt;
  logic                 pc_valid;
  logic                 pc_last;
  logic [PC_W-1:0]      pc      [NK];
  logic [PC_W-1:0]      pc_next [NK];
  logic [ACC_WIDTH-1:0] acc     [NK];
  logic [ACC_WIDTH-1:0] sum     [NK];
  logic [NK-1:0]        act_bin;

  function automatic logic [PC_W-1:0] popcount(input logic [SLICE_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < SLICE_W; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // A held result stalls the whole pipeline so no partial sum is ever lost.
  assign en          = !(out_valid && !out_ready);
  assign in_ready    = en;
  assign accept      = in_valid && en;
  assign last_beat   = (cnt == LAST_CNT);
  assign load_result = en && pc_valid && pc_last;

  // NOTE: every variable here is written on every pass of the loop, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      pc_next[k] = popcount(fmap_in ~^ weight[k*SLICE_W +: SLICE_W]);
      sum[k]     = acc[k] + ACC_WIDTH'(pc[k]);
      act_bin[k] = (sum[k] >= threshold[k*ACC_WIDTH +: ACC_WIDTH]) ^ polarity[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pc_valid <= 1'b0;
      pc_last  <= 1'b0;
      // NOTE: pc and acc are a handful of per-kernel registers, not a RAM, so a reset loop is cheap.
      for (int k = 0; k < NK; k++) pc[k] <= '0;
    end else if (flush) begin
      cnt      <= '0;
      pc_valid <= 1'b0;
      pc_last  <= 1'b0;
    end else if (en) begin
      pc_valid <= accept;
      pc_last  <= accept && last_beat;
      if (accept) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
        for (int k = 0; k < NK; k++) pc[k] <= pc_next[k];
      end
    end
  end

  // The last beat clears the accumulator in the same edge that publishes the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) acc[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < NK; k++) acc[k] <= '0;
    end else if (en && pc_valid) begin
      for (int k = 0; k < NK; k++) acc[k] <= pc_last ? '0 : sum[k];
    end
  end

  // Output register is deliberately outside the flush domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      acc_out   <= '0;
      bin_out   <= '0;
    end else if (load_result) begin
      out_valid <= 1'b1;
      bin_out   <= act_bin;
      for (int k = 0; k < NK; k++) acc_out[k*ACC_WIDTH +: ACC_WIDTH] <= sum[k];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
